// File: rtl/vga_timing_decoder.sv
// Recovers pixel position and lock status from raw VGA hs/vs sync inputs.
// Optional timing-error counter enabled by defining VGA_DEC_ERRCNT_EN.
module vga_timing_decoder #(
    parameter int H_TOTAL     = 800,
    parameter int H_START     = 144,
    parameter int H_ACTIVE    = 640,
    parameter int V_TOTAL     = 525,
    parameter int V_START     = 35,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hs,
    input  logic       vs,
    output logic       locked,
    output logic       de,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       frame_start,
    output logic [7:0] err_count
);

    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_BEG   = 10'(H_START);
    localparam logic [9:0] H_END   = 10'(H_START + H_ACTIVE);
    localparam logic [9:0] V_BEG   = 10'(V_START);
    localparam logic [9:0] V_END   = 10'(V_START + V_ACTIVE);
    localparam logic [9:0] CNT_MAX = 10'd1023;
    localparam logic [1:0] LOCK_N  = 2'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

    state_t     state_reg, state_next;
    logic [1:0] sync1_reg, sync2_reg, prev_reg;
    logic [1:0] fall;
    logic       hs_edge, vs_edge;
    logic [9:0] h_cnt_reg, h_cnt_next;
    logic [9:0] v_cnt_reg, v_cnt_next;
    logic [1:0] good_reg, good_next;
    logic       first_hs_reg, first_hs_next;
    logic       line_err, frame_err, any_err;
    logic       locked_reg, de_reg, frame_start_reg;
    logic       de_next;
    logic [9:0] x_reg, y_reg;

    // Bit 0 carries hs, bit 1 carries vs; flops idle high so reset makes no edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 2'b11;
            sync2_reg <= 2'b11;
            prev_reg  <= 2'b11;
        end else begin
            sync1_reg <= {vs, hs};
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    assign fall    = prev_reg & ~sync2_reg;
    assign hs_edge = fall[0];
    assign vs_edge = fall[1];

    always_comb begin
        h_cnt_next = h_cnt_reg;
        v_cnt_next = v_cnt_reg;
        if (hs_edge) begin
            h_cnt_next = 10'd0;
        end else if (h_cnt_reg != CNT_MAX) begin
            h_cnt_next = h_cnt_reg + 10'd1;
        end
        if (vs_edge) begin
            v_cnt_next = 10'd0;
        end else if (hs_edge && (v_cnt_reg != CNT_MAX)) begin
            v_cnt_next = v_cnt_reg + 10'd1;
        end
    end

    // A saturated counter means the sync has stopped; the edge check covers bad periods.
    assign line_err  = hs_edge ? (!first_hs_reg && (h_cnt_reg != H_LAST))
                               : (h_cnt_reg == CNT_MAX);
    assign frame_err = vs_edge ? (v_cnt_reg != V_LAST) : (v_cnt_reg == CNT_MAX);
    assign any_err   = line_err | frame_err;

    always_comb begin
        state_next    = state_reg;
        good_next     = good_reg;
        first_hs_next = first_hs_reg;
        if (hs_edge) begin
            first_hs_next = 1'b0;
        end
        case (state_reg)
            SEARCH: begin
                if (vs_edge) begin
                    state_next = TRACK;
                    good_next  = 2'd0;
                end
            end
            TRACK: begin
                if (any_err) begin
                    state_next    = SEARCH;
                    good_next     = 2'd0;
                    first_hs_next = 1'b1;
                end else if (vs_edge) begin
                    good_next = good_reg + 2'd1;
                    if (good_reg + 2'd1 == LOCK_N) begin
                        state_next = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (any_err) begin
                    state_next    = SEARCH;
                    good_next     = 2'd0;
                    first_hs_next = 1'b1;
                end
            end
            default: begin
                state_next = SEARCH;
                good_next  = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= SEARCH;
            good_reg     <= 2'd0;
            first_hs_reg <= 1'b1;
            h_cnt_reg    <= 10'd0;
            v_cnt_reg    <= 10'd0;
        end else begin
            state_reg    <= state_next;
            good_reg     <= good_next;
            first_hs_reg <= first_hs_next;
            h_cnt_reg    <= h_cnt_next;
            v_cnt_reg    <= v_cnt_next;
        end
    end

    assign de_next = locked_reg
                   && (h_cnt_reg >= H_BEG) && (h_cnt_reg < H_END)
                   && (v_cnt_reg >= V_BEG) && (v_cnt_reg < V_END);

    // Outputs trail the counters by one cycle; frame_start lines up with the counter load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked_reg      <= 1'b0;
            frame_start_reg <= 1'b0;
            de_reg          <= 1'b0;
            x_reg           <= 10'd0;
            y_reg           <= 10'd0;
        end else begin
            locked_reg      <= (state_next == LOCKED);
            frame_start_reg <= vs_edge && locked_reg;
            de_reg          <= de_next;
            x_reg           <= de_next ? (h_cnt_reg - H_BEG) : 10'd0;
            y_reg           <= de_next ? (v_cnt_reg - V_BEG) : 10'd0;
        end
    end

    assign locked      = locked_reg;
    assign frame_start = frame_start_reg;
    assign de          = de_reg;
    assign x           = x_reg;
    assign y           = y_reg;

`ifdef VGA_DEC_ERRCNT_EN
    logic [7:0] err_count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_reg <= 8'd0;
        end else if (any_err && (state_reg != SEARCH) && (err_count_reg != 8'hFF)) begin
            err_count_reg <= err_count_reg + 8'd1;
        end
    end

    assign err_count = err_count_reg;
`else
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_vga_timing_decoder.sv
// Randomized scoreboard bench for vga_timing_decoder using scaled-down frame timing.
module tb_vga_timing_decoder;

    localparam int HT    = 40;
    localparam int HST   = 10;
    localparam int HA    = 24;
    localparam int VT    = 20;
    localparam int VST   = 4;
    localparam int VA    = 12;
    localparam int LOCKN = 2;
    localparam int HSW   = 4;

    localparam int S_SEARCH = 0;
    localparam int S_TRACK  = 1;
    localparam int S_LOCKED = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hs = 1'b1;
    logic       vs = 1'b1;
    logic       locked, de, frame_start;
    logic [9:0] x, y;
    logic [7:0] err_count;

    vga_timing_decoder #(
        .H_TOTAL(HT), .H_START(HST), .H_ACTIVE(HA),
        .V_TOTAL(VT), .V_START(VST), .V_ACTIVE(VA), .LOCK_FRAMES(LOCKN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hs(hs), .vs(vs),
        .locked(locked), .de(de), .x(x), .y(y),
        .frame_start(frame_start), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; int px; int py; } pix_t;
    typedef struct { int cyc; bit lk; int err; bit fs; } ev_t;
    pix_t pixq[$];
    ev_t  evq[$];

    int checks = 0;
    int failures = 0;
    bit running = 0;

    // Frame-level reference state
    int m_state, m_good, m_err, m_last_hs, m_lines;
    bit m_first;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    function automatic int bump(input int e);
`ifdef VGA_DEC_ERRCNT_EN
        return (e < 255) ? e + 1 : e;
`else
        return e + 0;
`endif
    endfunction

    task automatic push_ev(input int c, input bit lk, input int err, input bit fs);
        ev_t e;
        e.cyc = c; e.lk = lk; e.err = err; e.fs = fs;
        evq.push_back(e);
    endtask

    // Called at each HS fall (cycle f) for a line lasting len clocks.
    task automatic model_line(input int f, input bit vs_fall, input int len);
        bit   lerr, ferr, was_locked;
        int   v;
        pix_t p;
        lerr = !m_first && ((f - m_last_hs) != HT);
        m_first = 0;
        ferr = vs_fall && (m_lines != VT - 1);
        was_locked = (m_state == S_LOCKED);
        if (m_state != S_SEARCH && (lerr || ferr)) begin
            m_err = bump(m_err);
            m_state = S_SEARCH;
            m_first = 1;
        end else if (vs_fall) begin
            if (m_state == S_SEARCH) begin
                m_state = S_TRACK;
                m_good = 0;
            end else if (m_state == S_TRACK) begin
                m_good++;
                if (m_good == LOCKN) m_state = S_LOCKED;
            end
        end
        if (vs_fall) m_lines = 0;
        else m_lines++;
        m_last_hs = f;
        push_ev(f + 3, m_state == S_LOCKED, m_err, vs_fall && was_locked);
        v = m_lines;
        if (m_state == S_LOCKED && v >= VST && v < VST + VA) begin
            for (int c = 0; c < HA; c++) begin
                if (HST + c < len) begin
                    p.cyc = f + 4 + HST + c; p.px = c; p.py = v - VST;
                    pixq.push_back(p);
                end
            end
        end
        // Counter saturates at 1023 before the next HS edge arrives
        if (len >= 1025) begin
            if (m_state != S_SEARCH) begin
                m_err = bump(m_err);
                m_first = 1;
            end
            m_state = S_SEARCH;
            push_ev(f + 3 + 1024, 0, m_err, 0);
        end
    endtask

    task automatic model_reset(input int r);
        m_state = S_SEARCH; m_good = 0; m_first = 1; m_err = 0; m_lines = 0;
        push_ev(r, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_line(input int len, input bit vs_low, input bit do_rst);
        int f;
        bit vfall;
        step();
        vfall = vs_low && (vs == 1'b1);
        hs = 1'b0;
        vs = ~vs_low;
        f = cyc;
        model_line(f, vfall, len);
        for (int i = 1; i < len; i++) begin
            step();
            if (i == HSW) hs = 1'b1;
            if (do_rst && i == 20) begin
                rst_n = 1'b0;
                model_reset(cyc);
            end
            if (do_rst && i == 21) rst_n = 1'b1;
        end
    endtask

    task automatic drive_frame(input int nlines, input int err_line, input int err_len,
                               input int rst_line);
        for (int l = 0; l < nlines; l++) begin
            drive_line((l == err_line) ? err_len : HT, l < 2, l == rst_line);
        end
    endtask

    bit exp_lk = 0;
    int exp_err = 0;
    bit exp_fs;
    bit exp_de;

    always @(negedge clk) begin
        if (running) begin
            exp_fs = 0;
            while (evq.size() > 0 && evq[0].cyc <= cyc) begin
                ev_t e;
                e = evq.pop_front();
                exp_lk = e.lk;
                exp_err = e.err;
                if (e.cyc == cyc && e.fs) exp_fs = 1;
            end
            check("locked", locked, exp_lk);
            check("frame_start", frame_start, exp_fs);
            check("err_count", err_count, exp_err);
            while (pixq.size() > 0 && pixq[0].cyc < cyc) void'(pixq.pop_front());
            exp_de = (pixq.size() > 0) && (pixq[0].cyc == cyc);
            check("de", de, exp_de);
            if (exp_de) begin
                pix_t p;
                p = pixq.pop_front();
                check("x", x, p.px);
                check("y", y, p.py);
            end else begin
                check("x_idle", x, 0);
                check("y_idle", y, 0);
            end
        end
    end

    initial begin
        int r;
        m_state = S_SEARCH; m_good = 0; m_first = 1; m_err = 0;
        m_lines = 0; m_last_hs = 0;
        running = 1;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (5) step();

        // Acquire lock on clean timing
        repeat (5) drive_frame(VT, -1, HT, -1);
        // One short line while locked, then relock
        drive_frame(VT, $urandom_range(1, VT - 2), HT - 1, -1);
        repeat (4) drive_frame(VT, -1, HT, -1);
        // HS stops long enough for the line counter to saturate
        drive_frame(VT, $urandom_range(5, 10), 1100, -1);
        repeat (4) drive_frame(VT, -1, HT, -1);
        // Reset pulse in the last (blanking) line of a locked frame
        drive_frame(VT, -1, HT, VT - 1);
        repeat (4) drive_frame(VT, -1, HT, -1);
        // Random mix of clean frames, bad line lengths and bad frame lengths
        for (int k = 0; k < 8; k++) begin
            r = $urandom_range(0, 3);
            case (r)
                1: drive_frame(VT, $urandom_range(0, VT - 1),
                               ($urandom_range(0, 1) == 1) ? HT + $urandom_range(1, 3)
                                                          : HT - $urandom_range(1, 3), -1);
                2: drive_frame(($urandom_range(0, 1) == 1) ? VT + 1 : VT - 1, -1, HT, -1);
                default: drive_frame(VT, -1, HT, -1);
            endcase
        end
        repeat (4) drive_frame(VT, -1, HT, -1);
        repeat (10) step();
        check("pixels_outstanding", pixq.size(), 0);
        running = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
